// File: rtl/display_defs.sv
// Shared definitions for the 7-segment scan path: digit code map and default digit count.
package display_defs;

  localparam int unsigned DIGITS_DEFAULT = 8;
  localparam int unsigned CODE_W         = 4;

  localparam logic [CODE_W-1:0] CODE_A     = 4'd10;
  localparam logic [CODE_W-1:0] CODE_T     = 4'd11;
  localparam logic [CODE_W-1:0] CODE_U     = 4'd12;
  localparam logic [CODE_W-1:0] CODE_BLANK = 4'd13;
  localparam logic [CODE_W-1:0] CODE_E     = 4'd14;
  localparam logic [CODE_W-1:0] CODE_OFF   = 4'd15;

  // Codes that keep the anode off regardless of blanking mode.
  function automatic logic code_is_dark(input logic [CODE_W-1:0] code);
    return (code == CODE_BLANK) || (code == CODE_OFF);
  endfunction

endpackage

// File: rtl/refresh_tick.sv
// Refresh prescaler: one-cycle tick every REFRESH_DIV clocks (REFRESH_DIV >= 2).
module refresh_tick #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick_q is high exactly while cnt_q sits at its terminal value.
  always_comb begin
    cnt_d  = tick_q ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == CNT_W'(REFRESH_DIV - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 7-segment scan driver with frame-aligned double buffering
// and optional leading-zero blanking.
module display_scan
  import display_defs::*;
#(
  parameter int unsigned DIGITS      = DIGITS_DEFAULT,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [CODE_W*DIGITS-1:0]   value,
  input  logic                       blank_lz,
  output logic [CODE_W-1:0]          q,
  output logic [DIGITS-1:0]          an,
  output logic                       frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef logic [DIGITS-1:0][CODE_W-1:0] codes_t;

  logic              tick;
  logic              wrap;
  logic [IDX_W-1:0]  idx_q, idx_d;
  codes_t            shadow_q, shadow_d;
  codes_t            active_q, active_d;
  logic              pending_q, pending_d;
  logic [CODE_W-1:0] q_q, q_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q, frame_done_d;
  logic [DIGITS-1:0] dark;
  logic              lz_run;

  refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign wrap = tick && (idx_q == IDX_W'(DIGITS - 1));

  // Digit index and frame-aligned commit of the shadow buffer.
  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end
    if (wrap) begin
      if (load) begin
        active_d  = codes_t'(value);
        shadow_d  = codes_t'(value);
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (load) begin
      shadow_d  = codes_t'(value);
      pending_d = 1'b1;
    end
  end

  // Dark digits: blank codes, plus leading zeros scanned from the top when enabled.
  always_comb begin
    dark   = '0;
    lz_run = blank_lz;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      lz_run  = lz_run && (active_d[k] == '0);
      dark[k] = code_is_dark(active_d[k]) || ((k != 0) && lz_run);
    end
  end

  always_comb begin
    q_d          = active_d[idx_d];
    an_d         = '1;
    if (!dark[idx_d]) begin
      an_d[idx_d] = 1'b0;
    end
    frame_done_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      q_q          <= '0;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      q_q          <= q_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign q          = q_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
